// File: rtl/rv32i_pkg.sv
// Shared RV32I decode types: opcodes, immediate formats, ALU ops and the packed
// control word carried from ID into EX.
package rv32i_pkg;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    typedef enum logic [2:0] {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_sel_e;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR,
        ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_PASSB
    } alu_op_e;

    typedef enum logic [1:0] {SRC_A_RS1, SRC_A_PC, SRC_A_ZERO} src_a_e;
    typedef enum logic [0:0] {SRC_B_RS2, SRC_B_IMM} src_b_e;

    typedef struct packed {
        alu_op_e    alu_op;
        src_a_e     src_a;
        src_b_e     src_b;
        logic       reg_we;
        logic       mem_re;
        logic       mem_we;
        logic [2:0] funct3;
        logic       branch;
        logic       jal;
        logic       jalr;
        logic       illegal;
    } ctrl_t;

    function automatic logic [31:0] imm_gen(input logic [31:0] i, input imm_sel_e sel);
        logic [31:0] imm;
        case (sel)
            IMM_S:   imm = {{20{i[31]}}, i[31:25], i[11:7]};
            IMM_B:   imm = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
            IMM_U:   imm = {i[31:12], 12'b0};
            IMM_J:   imm = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
            default: imm = {{20{i[31]}}, i[31:20]};
        endcase
        return imm;
    endfunction

    // alt selects SUB/SRA; callers decide when funct7[5] is meaningful.
    function automatic alu_op_e alu_from_f3(input logic [2:0] f3, input logic alt);
        alu_op_e op;
        case (f3)
            3'b000:  op = alt ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/rv32i_regfile.sv
// Integer register file, 2 combinational reads / 1 write, x0 reads as zero.
// Define WB_BYPASS_EN to forward a same-cycle writeback onto the read ports.
module rv32i_regfile
    import rv32i_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int NUM_REGS = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [4:0]      i_raddr1,
    input  logic [4:0]      i_raddr2,
    output logic [XLEN-1:0] o_rdata1,
    output logic [XLEN-1:0] o_rdata2,
    input  logic            i_we,
    input  logic [4:0]      i_waddr,
    input  logic [XLEN-1:0] i_wdata
);

    logic [XLEN-1:0] r_regs [NUM_REGS];

    function automatic logic [XLEN-1:0] read_port(input logic [4:0] addr);
        logic [XLEN-1:0] data;
        data = (addr == 5'd0) ? '0 : r_regs[addr];
`ifdef WB_BYPASS_EN
        if (i_we && (i_waddr != 5'd0) && (i_waddr == addr)) begin
            data = i_wdata;
        end
`endif
        return data;
    endfunction

    always_comb begin
        o_rdata1 = read_port(i_raddr1);
        o_rdata2 = read_port(i_raddr2);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (i_we && (i_waddr != 5'd0)) begin
            r_regs[i_waddr] <= i_wdata;
        end
    end

endmodule

// File: rtl/decode_stage.sv
// RV32I ID stage: decode, register read and the ID/EX register with load-use
// stall and flush. Define WB_BYPASS_EN to bypass writeback into reads/held operands.
module decode_stage
    import rv32i_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int NUM_REGS = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            if_valid,
    input  logic [XLEN-1:0] if_pc,
    input  logic [XLEN-1:0] if_instr,
    output logic            id_ready,
    input  logic            flush,
    input  logic            ex_ready,
    input  logic            wb_en,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_data,
    output logic            id_valid,
    output logic [XLEN-1:0] id_pc,
    output logic [4:0]      id_rs1,
    output logic [4:0]      id_rs2,
    output logic [4:0]      id_rd,
    output logic [XLEN-1:0] id_rs1_data,
    output logic [XLEN-1:0] id_rs2_data,
    output logic [XLEN-1:0] id_imm,
    output ctrl_t           id_ctrl
);

    // Handshake: ID/EX loads on if_valid && id_ready; EX consumes on id_valid && ex_ready.
    logic            r_valid;
    logic [XLEN-1:0] r_pc, r_rs1_data, r_rs2_data, r_imm;
    logic [4:0]      r_rs1, r_rs2, r_rd;
    ctrl_t           r_ctrl;

    logic [6:0]      w_opcode, w_funct7;
    logic [2:0]      w_funct3;
    logic [4:0]      w_rs1_idx, w_rs2_idx, w_rd_idx;
    logic [XLEN-1:0] w_rdata1, w_rdata2, w_imm;
    imm_sel_e        w_imm_sel;
    ctrl_t           w_ctrl;
    logic            w_use_rs1, w_use_rs2, w_bad, w_illegal;
    logic            w_load_use, w_ready, w_load;

    assign w_opcode  = if_instr[6:0];
    assign w_rd_idx  = if_instr[11:7];
    assign w_funct3  = if_instr[14:12];
    assign w_rs1_idx = if_instr[19:15];
    assign w_rs2_idx = if_instr[24:20];
    assign w_funct7  = if_instr[31:25];

    rv32i_regfile #(.XLEN(XLEN), .NUM_REGS(NUM_REGS)) u_regfile (
        .clk      (clk),
        .reset    (reset),
        .i_raddr1 (w_rs1_idx),
        .i_raddr2 (w_rs2_idx),
        .o_rdata1 (w_rdata1),
        .o_rdata2 (w_rdata2),
        .i_we     (wb_en),
        .i_waddr  (wb_rd),
        .i_wdata  (wb_data)
    );

    always_comb begin
        w_ctrl    = '0;
        w_imm_sel = IMM_I;
        w_use_rs1 = 1'b0;
        w_use_rs2 = 1'b0;
        w_bad     = 1'b0;
        case (w_opcode)
            OPC_LUI: begin
                w_imm_sel = IMM_U; w_ctrl.alu_op = ALU_PASSB;
                w_ctrl.src_a = SRC_A_ZERO; w_ctrl.src_b = SRC_B_IMM; w_ctrl.reg_we = 1'b1;
            end
            OPC_AUIPC: begin
                w_imm_sel = IMM_U; w_ctrl.src_a = SRC_A_PC;
                w_ctrl.src_b = SRC_B_IMM; w_ctrl.reg_we = 1'b1;
            end
            OPC_JAL: begin
                w_imm_sel = IMM_J; w_ctrl.src_a = SRC_A_PC; w_ctrl.src_b = SRC_B_IMM;
                w_ctrl.reg_we = 1'b1; w_ctrl.jal = 1'b1;
            end
            OPC_JALR: begin
                w_use_rs1 = 1'b1; w_ctrl.src_b = SRC_B_IMM;
                w_ctrl.reg_we = 1'b1; w_ctrl.jalr = 1'b1;
            end
            OPC_BRANCH: begin
                w_imm_sel = IMM_B; w_use_rs1 = 1'b1; w_use_rs2 = 1'b1;
                w_ctrl.alu_op = ALU_SUB; w_ctrl.branch = 1'b1;
            end
            OPC_LOAD: begin
                w_use_rs1 = 1'b1; w_ctrl.src_b = SRC_B_IMM;
                w_ctrl.reg_we = 1'b1; w_ctrl.mem_re = 1'b1;
            end
            OPC_STORE: begin
                w_imm_sel = IMM_S; w_use_rs1 = 1'b1; w_use_rs2 = 1'b1;
                w_ctrl.src_b = SRC_B_IMM; w_ctrl.mem_we = 1'b1;
            end
            OPC_OP_IMM: begin
                // Only shifts carry a funct7; for other ops bit 30 is immediate data.
                w_use_rs1 = 1'b1; w_ctrl.src_b = SRC_B_IMM; w_ctrl.reg_we = 1'b1;
                w_ctrl.alu_op = alu_from_f3(w_funct3, (w_funct3 == 3'b101) && if_instr[30]);
                if (w_funct3 == 3'b001) w_bad = (w_funct7 != 7'h00);
                if (w_funct3 == 3'b101) w_bad = (w_funct7 != 7'h00) && (w_funct7 != 7'h20);
            end
            OPC_OP: begin
                w_use_rs1 = 1'b1; w_use_rs2 = 1'b1; w_ctrl.reg_we = 1'b1;
                w_ctrl.alu_op = alu_from_f3(w_funct3, if_instr[30]);
                w_bad = !((w_funct7 == 7'h00) ||
                          ((w_funct7 == 7'h20) && ((w_funct3 == 3'b000) || (w_funct3 == 3'b101))));
            end
            OPC_FENCE, OPC_SYSTEM: begin
            end
            default: w_bad = 1'b1;
        endcase
        w_illegal = w_bad || (if_instr[1:0] != 2'b11) || (if_instr == '0) || (if_instr == '1);
        if (w_illegal) begin
            w_ctrl         = '0;
            w_ctrl.illegal = 1'b1;
            w_use_rs1      = 1'b0;
            w_use_rs2      = 1'b0;
        end
        w_ctrl.funct3 = w_funct3;
    end

    assign w_imm = imm_gen(if_instr, w_imm_sel);

    assign w_load_use = if_valid && r_valid && r_ctrl.mem_re && (r_rd != 5'd0) &&
                        ((w_use_rs1 && (w_rs1_idx == r_rd)) || (w_use_rs2 && (w_rs2_idx == r_rd)));
    assign w_ready    = flush || (!w_load_use && (ex_ready || !r_valid));
    assign w_load     = if_valid && w_ready && !flush;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid    <= 1'b0;
            r_pc       <= '0;
            r_rs1      <= '0;
            r_rs2      <= '0;
            r_rd       <= '0;
            r_rs1_data <= '0;
            r_rs2_data <= '0;
            r_imm      <= '0;
            r_ctrl     <= '0;
        end else if (flush) begin
            r_valid <= 1'b0;
        end else if (w_load) begin
            r_valid    <= 1'b1;
            r_pc       <= if_pc;
            r_rs1      <= w_rs1_idx;
            r_rs2      <= w_rs2_idx;
            r_rd       <= w_rd_idx;
            r_rs1_data <= w_rdata1;
            r_rs2_data <= w_rdata2;
            r_imm      <= w_imm;
            r_ctrl     <= w_ctrl;
        end else if (ex_ready) begin
            r_valid <= 1'b0;
        end else begin
`ifdef WB_BYPASS_EN
            if (wb_en && (wb_rd != 5'd0) && (wb_rd == r_rs1)) r_rs1_data <= wb_data;
            if (wb_en && (wb_rd != 5'd0) && (wb_rd == r_rs2)) r_rs2_data <= wb_data;
`endif
        end
    end

    assign id_ready    = w_ready;
    assign id_valid    = r_valid;
    assign id_pc       = r_pc;
    assign id_rs1      = r_rs1;
    assign id_rs2      = r_rs2;
    assign id_rd       = r_rd;
    assign id_rs1_data = r_rs1_data;
    assign id_rs2_data = r_rs2_data;
    assign id_imm      = r_imm;
    assign id_ctrl     = r_ctrl;

endmodule

// File: tb/tb_decode_stage.sv
// Randomized bench for decode_stage against a behavioural ID-stage model,
// plus directed scenarios for stall, hold, flush, bypass and illegal words.
module tb_decode_stage;
    import rv32i_pkg::*;

    logic        clk = 1'b0;
    logic        reset, if_valid, flush, ex_ready, wb_en;
    logic [31:0] if_pc, if_instr, wb_data;
    logic [4:0]  wb_rd;
    logic        id_ready, id_valid;
    logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    ctrl_t       id_ctrl;

    decode_stage dut (
        .clk(clk), .reset(reset), .if_valid(if_valid), .if_pc(if_pc), .if_instr(if_instr),
        .id_ready(id_ready), .flush(flush), .ex_ready(ex_ready), .wb_en(wb_en),
        .wb_rd(wb_rd), .wb_data(wb_data), .id_valid(id_valid), .id_pc(id_pc),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_rs1_data(id_rs1_data),
        .id_rs2_data(id_rs2_data), .id_imm(id_imm), .id_ctrl(id_ctrl)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Architectural state of the model: register values and the ID/EX contents.
    logic [31:0] regs [32];
    bit          m_valid;
    logic [31:0] m_pc, m_d1, m_d2, m_imm;
    logic [4:0]  m_rs1, m_rs2, m_rd;
    ctrl_t       m_ctrl;
    logic        last_ready;

    function automatic void ref_decode(input logic [31:0] w, output ctrl_t c,
                                       output logic [31:0] imm, output bit u1, output bit u2);
        logic [6:0] op;
        logic [2:0] f3;
        logic [6:0] f7;
        bit         ok;
        int         fmt, t;
        alu_op_e    tbl [8];
        tbl = '{ALU_ADD, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_OR, ALU_AND};
        op = w[6:0]; f3 = w[14:12]; f7 = w[31:25];
        c = '0; u1 = 0; u2 = 0; ok = 1; fmt = 0;
        case (op)
            7'h37: begin fmt = 3; c.alu_op = ALU_PASSB; c.src_a = SRC_A_ZERO; c.src_b = SRC_B_IMM; c.reg_we = 1; end
            7'h17: begin fmt = 3; c.src_a = SRC_A_PC; c.src_b = SRC_B_IMM; c.reg_we = 1; end
            7'h6F: begin fmt = 4; c.src_a = SRC_A_PC; c.src_b = SRC_B_IMM; c.reg_we = 1; c.jal = 1; end
            7'h67: begin u1 = 1; c.src_b = SRC_B_IMM; c.reg_we = 1; c.jalr = 1; end
            7'h63: begin fmt = 2; u1 = 1; u2 = 1; c.alu_op = ALU_SUB; c.branch = 1; end
            7'h03: begin u1 = 1; c.src_b = SRC_B_IMM; c.reg_we = 1; c.mem_re = 1; end
            7'h23: begin fmt = 1; u1 = 1; u2 = 1; c.src_b = SRC_B_IMM; c.mem_we = 1; end
            7'h13: begin
                u1 = 1; c.src_b = SRC_B_IMM; c.reg_we = 1; c.alu_op = tbl[f3];
                if (f3 == 1 && f7 != 0) ok = 0;
                if (f3 == 5) begin
                    if (f7 == 7'h20) c.alu_op = ALU_SRA;
                    else if (f7 != 0) ok = 0;
                end
            end
            7'h33: begin
                u1 = 1; u2 = 1; c.reg_we = 1; c.alu_op = tbl[f3];
                if (f7 == 7'h20 && f3 == 0) c.alu_op = ALU_SUB;
                else if (f7 == 7'h20 && f3 == 5) c.alu_op = ALU_SRA;
                else if (f7 != 0) ok = 0;
            end
            7'h0F, 7'h73: ;
            default: ok = 0;
        endcase
        if (!ok || w[1:0] != 2'b11 || w == 32'h0 || w == 32'hFFFF_FFFF) begin
            c = '0; c.illegal = 1; u1 = 0; u2 = 0;
        end
        c.funct3 = f3;
        case (fmt)
            1:       t = $signed({w[31:25], w[11:7]});
            2:       t = $signed({w[31], w[7], w[30:25], w[11:8], 1'b0});
            3:       t = w & 32'hFFFF_F000;
            4:       t = $signed({w[31], w[19:12], w[20], w[30:21], 1'b0});
            default: t = $signed(w[31:20]);
        endcase
        imm = t;
    endfunction

    function automatic logic [31:0] ref_read(input logic [4:0] idx, input logic we,
                                             input logic [4:0] wrd, input logic [31:0] wd);
        if (idx == 0) return 32'h0;
`ifdef WB_BYPASS_EN
        if (we && wrd == idx) return wd;
`endif
        return regs[idx];
    endfunction

    // One clock: drive inputs, check id_ready, advance the model, check ID/EX.
    task automatic step(input logic v, input logic [31:0] pc, input logic [31:0] ins,
                        input logic fl, input logic exr, input logic we,
                        input logic [4:0] wrd, input logic [31:0] wd);
        ctrl_t       c;
        logic [31:0] imm;
        bit          u1, u2, lu, rdy;
        logic [4:0]  s1, s2;
        if_valid = v; if_pc = pc; if_instr = ins; flush = fl; ex_ready = exr;
        wb_en = we; wb_rd = wrd; wb_data = wd;
        #1;
        ref_decode(ins, c, imm, u1, u2);
        s1 = ins[19:15]; s2 = ins[24:20];
        lu  = v && m_valid && m_ctrl.mem_re && m_rd != 0 &&
              ((u1 && s1 == m_rd) || (u2 && s2 == m_rd));
        rdy = fl || (!lu && (exr || !m_valid));
        last_ready = id_ready;
        check("id_ready", id_ready, rdy);
        if (fl) m_valid = 0;
        else if (v && rdy) begin
            m_valid = 1; m_pc = pc; m_rs1 = s1; m_rs2 = s2; m_rd = ins[11:7];
            m_d1 = ref_read(s1, we, wrd, wd); m_d2 = ref_read(s2, we, wrd, wd);
            m_imm = imm; m_ctrl = c;
        end else if (exr) m_valid = 0;
        else begin
`ifdef WB_BYPASS_EN
            if (we && wrd != 0 && wrd == m_rs1) m_d1 = wd;
            if (we && wrd != 0 && wrd == m_rs2) m_d2 = wd;
`endif
        end
        if (we && wrd != 0) regs[wrd] = wd;
        @(posedge clk);
        #1;
        check("id_valid", id_valid, m_valid);
        check("id_pc", id_pc, m_pc);
        check("id_rs1", id_rs1, m_rs1);
        check("id_rs2", id_rs2, m_rs2);
        check("id_rd", id_rd, m_rd);
        check("id_rs1_data", id_rs1_data, m_d1);
        check("id_rs2_data", id_rs2_data, m_d2);
        check("id_imm", id_imm, m_imm);
        check("id_ctrl", id_ctrl, m_ctrl);
    endtask

    function automatic logic [31:0] rand_instr();
        logic [6:0]  ops [11];
        logic [31:0] w;
        int          pick;
        ops  = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h0F, 7'h73};
        pick = $urandom_range(0, 19);
        if (pick == 0) return 32'h0;
        if (pick == 1) return 32'hFFFF_FFFF;
        w = $urandom;
        if (pick == 2) return w;
        w[6:0]   = ops[$urandom_range(0, 10)];
        w[11:7]  = 5'($urandom_range(0, 7));
        w[19:15] = 5'($urandom_range(0, 7));
        w[24:20] = 5'($urandom_range(0, 7));
        case ($urandom_range(0, 3))
            0, 1:    w[31:25] = 7'h00;
            2:       w[31:25] = 7'h20;
            default: ;
        endcase
        if (pick == 3) w[1:0] = 2'($urandom_range(0, 2));
        return w;
    endfunction

    localparam logic [31:0] I_ADDI = 32'hFFF0_0293;  // addi x5,x0,-1
    localparam logic [31:0] I_LW   = 32'h0002_A303;  // lw x6,0(x5)
    localparam logic [31:0] I_ADD  = 32'h0063_03B3;  // add x7,x6,x6
    localparam logic [31:0] I_ADD3 = 32'h0001_80B3;  // add x1,x3,x0
    localparam logic [31:0] I_ADD0 = 32'h0000_00B3;  // add x1,x0,x0

    initial begin
        for (int i = 0; i < 32; i++) regs[i] = 32'h0;
        m_valid = 0; m_pc = 0; m_d1 = 0; m_d2 = 0; m_imm = 0;
        m_rs1 = 0; m_rs2 = 0; m_rd = 0; m_ctrl = '0;
        reset = 1; if_valid = 0; if_pc = 0; if_instr = 0; flush = 0;
        ex_ready = 1; wb_en = 0; wb_rd = 0; wb_data = 0;
        repeat (3) @(posedge clk);
        #1;
        reset = 0;
        #1;
        check("rst_valid", id_valid, 0);
        check("rst_pc", id_pc, 0);
        check("rst_imm", id_imm, 0);
        check("rst_ctrl", id_ctrl, 0);
        check("rst_ready", id_ready, 1);

        step(1, 32'h100, I_ADDI, 0, 1, 0, 0, 0);
        check("addi_imm", id_imm, 32'hFFFF_FFFF);
        check("addi_rd", id_rd, 5);
        check("addi_alu", id_ctrl.alu_op, ALU_ADD);
        check("addi_srcb", id_ctrl.src_b, SRC_B_IMM);
        check("addi_we", id_ctrl.reg_we, 1);

        step(1, 32'h104, I_LW, 0, 1, 0, 0, 0);
        step(1, 32'h108, I_ADD, 0, 1, 0, 0, 0);
        check("lu_ready", last_ready, 0);
        check("lu_bubble", id_valid, 0);
        step(1, 32'h108, I_ADD, 0, 1, 0, 0, 0);
        check("lu_issue", id_valid, 1);
        check("lu_issue_rd", id_rd, 7);

        step(1, 32'h200, I_ADDI, 0, 1, 0, 0, 0);
        for (int k = 0; k < 3; k++) begin
            step(1, 32'h204, I_ADD3, 0, 0, 0, 0, 0);
            check("hold_ready", last_ready, 0);
            check("hold_pc", id_pc, 32'h200);
        end
        step(1, 32'h204, I_ADD3, 0, 1, 0, 0, 0);
        check("hold_release_pc", id_pc, 32'h204);

        step(1, 32'h300, I_LW, 0, 1, 0, 0, 0);
        step(1, 32'h304, I_ADD, 1, 1, 0, 0, 0);
        check("flush_ready", last_ready, 1);
        check("flush_valid", id_valid, 0);
        step(1, 32'h304, I_ADD, 0, 1, 0, 0, 0);
        check("flush_clears", id_valid, 1);

        step(1, 32'h400, I_ADD3, 0, 1, 1, 3, 32'hDEAD_BEEF);
`ifdef WB_BYPASS_EN
        check("wb_bypass", id_rs1_data, 32'hDEAD_BEEF);
`else
        check("wb_bypass", id_rs1_data, 32'h0);
`endif
        step(1, 32'h404, I_ADD3, 0, 1, 0, 0, 0);
        check("wb_written", id_rs1_data, 32'hDEAD_BEEF);

        step(1, 32'h500, 32'h0000_0000, 0, 1, 0, 0, 0);
        check("zero_illegal", id_ctrl.illegal, 1);
        check("zero_we", id_ctrl.reg_we, 0);
        step(1, 32'h504, 32'hFFFF_FFFF, 0, 1, 0, 0, 0);
        check("ones_illegal", id_ctrl.illegal, 1);
        check("ones_we", id_ctrl.reg_we, 0);
        step(1, 32'h508, I_ADD0, 0, 1, 1, 0, 32'h1234_5678);
        step(1, 32'h50C, I_ADD0, 0, 1, 0, 0, 0);
        check("x0_read", id_rs1_data, 32'h0);

        for (int n = 0; n < 1500; n++) begin
            step($urandom_range(0, 3) != 0, $urandom & 32'hFFFF_FFFC, rand_instr(),
                 $urandom_range(0, 9) == 0, $urandom_range(0, 3) != 0,
                 $urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)), $urandom);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
